int_seq: RTL and testbench

//  Interrupt/reset sequencer directly upstream of proc: conditions RESET, NMI and IRQ sources
//  and presents one prioritised request plus vector address at an instruction boundary.

---
 rtl/mos6502_pkg.sv | 34 +++
 rtl/int_seq_sig_sync.sv | 29 ++
 rtl/int_seq.sv | 125 ++++++++++++
 tb/tb_int_seq.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mos6502_pkg.sv
// Shared types and vector addresses for the interrupt/reset sequencer.
package mos6502_pkg;

  typedef enum logic [1:0] {
    KindNone  = 2'b00,
    KindIrq   = 2'b01,
    KindNmi   = 2'b10,
    KindReset = 2'b11
  } int_kind_t;

  localparam logic [15:0] VEC_NMI = 16'hFFFA;
  localparam logic [15:0] VEC_RST = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ = 16'hFFFE;

  typedef enum logic [1:0] {
    StRstHold,
    StIdle,
    StReq,
    StService
  } int_seq_state_t;

  function automatic logic [15:0] kind_vector(input int_kind_t kind);
    logic [15:0] vec;
    vec = VEC_RST;
    unique case (kind)
      KindIrq:   vec = VEC_IRQ;
      KindNmi:   vec = VEC_NMI;
      KindReset: vec = VEC_RST;
      default:   vec = VEC_RST;
    endcase
    return vec;
  endfunction

endpackage

// File: rtl/int_seq_sig_sync.sv
// Multi-flop synchroniser for an active-low async input, with a falling-edge pulse.
module sig_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic sync_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] stage_q;
  logic                   prev_q;

  // Preset to the inactive (high) level so reset release cannot fake an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '1;
      prev_q  <= 1'b1;
    end else begin
      stage_q <= {stage_q[SYNC_STAGES-2:0], sig_i};
      prev_q  <= stage_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = stage_q[SYNC_STAGES-1];
  assign fall_o = prev_q & ~stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/int_seq.sv
// Interrupt/reset sequencer: prioritises RESET > NMI > IRQ and hands one request plus its
// vector address to the processor at an opcode-fetch boundary.
module int_seq
  import mos6502_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RST_CYCLES  = 6
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        p_i,
  input  logic        fetch_boundary,
  input  logic        int_ack,
  input  logic        int_done,
  output logic        int_req,
  output logic [1:0]  int_kind,
  output logic [15:0] int_vector,
  output logic        nmi_pending
);

  localparam int unsigned CntW = $clog2(RST_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(RST_CYCLES - 1);

  int_seq_state_t  state_q;
  logic [CntW-1:0] cnt_q;
  logic            int_req_q;
  int_kind_t       kind_q;
  logic [15:0]     vector_q;
  logic            nmi_pending_q;

  logic nmi_fall;
  logic irq_sync;
  logic unused_nmi_sync;
  logic unused_irq_fall;

  sig_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_nmi_sync (
    .clk_i (clk),
    .rst_ni(resetn),
    .sig_i (nmi_n),
    .sync_o(unused_nmi_sync),
    .fall_o(nmi_fall)
  );

  sig_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_irq_sync (
    .clk_i (clk),
    .rst_ni(resetn),
    .sig_i (irq_n),
    .sync_o(irq_sync),
    .fall_o(unused_irq_fall)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= StRstHold;
      cnt_q         <= '0;
      int_req_q     <= 1'b0;
      kind_q        <= KindReset;
      vector_q      <= VEC_RST;
      nmi_pending_q <= 1'b0;
    end else begin
      if (nmi_fall) begin
        nmi_pending_q <= 1'b1;
      end
      unique case (state_q)
        StRstHold: begin
          if (cnt_q == CntMax) begin
            state_q   <= StReq;
            int_req_q <= 1'b1;
            kind_q    <= KindReset;
            vector_q  <= kind_vector(KindReset);
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StIdle: begin
          if (fetch_boundary) begin
            if (nmi_pending_q) begin
              state_q   <= StReq;
              int_req_q <= 1'b1;
              kind_q    <= KindNmi;
              vector_q  <= kind_vector(KindNmi);
            end else if (!irq_sync && !p_i) begin
              state_q   <= StReq;
              int_req_q <= 1'b1;
              kind_q    <= KindIrq;
              vector_q  <= kind_vector(KindIrq);
            end
          end
        end
        StReq: begin
          // Acceptance beats a same-cycle hijack; the pending NMI is then taken next time.
          if (int_ack) begin
            state_q   <= StService;
            int_req_q <= 1'b0;
            if (kind_q == KindNmi && !nmi_fall) begin
              nmi_pending_q <= 1'b0;
            end
          end else if (kind_q == KindIrq && nmi_pending_q) begin
            kind_q   <= KindNmi;
            vector_q <= kind_vector(KindNmi);
          end
        end
        StService: begin
          if (int_done) begin
            state_q <= StIdle;
            kind_q  <= KindNone;
          end
        end
        default: state_q <= StRstHold;
      endcase
    end
  end

  assign int_req     = int_req_q;
  assign int_kind    = kind_q;
  assign int_vector  = vector_q;
  assign nmi_pending = nmi_pending_q;

endmodule

// File: tb/tb_int_seq.sv
// Self-checking bench for int_seq: directed scenarios plus randomised IRQ/mask patterns.
module tb_int_seq;

  localparam int SYNC_STAGES = 2;
  localparam int RST_CYCLES  = 6;

  logic        clk = 1'b0;
  logic        resetn;
  logic        nmi_n;
  logic        irq_n;
  logic        p_i;
  logic        fetch_boundary;
  logic        int_ack;
  logic        int_done;
  logic        int_req;
  logic [1:0]  int_kind;
  logic [15:0] int_vector;
  logic        nmi_pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  int_seq #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_CYCLES (RST_CYCLES)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .nmi_n         (nmi_n),
    .irq_n         (irq_n),
    .p_i           (p_i),
    .fetch_boundary(fetch_boundary),
    .int_ack       (int_ack),
    .int_done      (int_done),
    .int_req       (int_req),
    .int_kind      (int_kind),
    .int_vector    (int_vector),
    .nmi_pending   (nmi_pending)
  );

  // Reference rules: priority choice at a boundary and the fixed vector table.
  function automatic logic [1:0] ref_kind(input bit nmi, input bit irq_lvl_n, input bit mask);
    if (nmi) return 2'b10;
    if (!irq_lvl_n && !mask) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [15:0] ref_vec(input logic [1:0] kind);
    case (kind)
      2'b01:   return 16'hFFFE;
      2'b10:   return 16'hFFFA;
      default: return 16'hFFFC;
    endcase
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; nmi_n = 1'b1; irq_n = 1'b1; p_i = 1'b1;
    fetch_boundary = 1'b0; int_ack = 1'b0; int_done = 1'b0;
    step(4);
    checks++;
    if ({int_req, int_kind, int_vector, nmi_pending} !== {1'b0, 2'b11, 16'hFFFC, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got req=%b kind=%b vec=%h pend=%b, want 0 11 fffc 0",
               int_req, int_kind, int_vector, nmi_pending);
    end
    resetn = 1'b1;
    for (int i = 1; i <= RST_CYCLES; i++) begin
      step();
      checks++;
      if (int_req !== (i == RST_CYCLES)) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got req=%b want %b", i, int_req, i == RST_CYCLES);
      end
    end
    checks++;
    if ({int_kind, int_vector} !== {2'b11, ref_vec(2'b11)}) begin
      errors++;
      $display("FAIL reset_req: got kind=%b vec=%h want 11 fffc", int_kind, int_vector);
    end
    int_ack = 1'b1; step(); int_ack = 1'b0;
    checks++;
    if (int_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_ack: got req=%b want 0", int_req);
    end
    int_done = 1'b1; step(); int_done = 1'b0;
    checks++;
    if (int_kind !== 2'b00) begin
      errors++;
      $display("FAIL reset_done: got kind=%b want 00", int_kind);
    end
  endtask

  task automatic test_irq_random();
    logic       lvl;
    logic       msk;
    logic [1:0] exp_kind;
    for (int it = 0; it < 16; it++) begin
      lvl = 1'($urandom_range(0, 1));
      msk = 1'($urandom_range(0, 1));
      irq_n = lvl; p_i = msk;
      step(SYNC_STAGES + 1 + $urandom_range(0, 3));
      checks++;
      if (int_req !== 1'b0) begin
        errors++;
        $display("FAIL irq_no_boundary it %0d: got req=%b want 0", it, int_req);
      end
      fetch_boundary = 1'b1; step(); fetch_boundary = 1'b0;
      exp_kind = ref_kind(1'b0, lvl, msk);
      checks++;
      if (int_req !== (exp_kind != 2'b00) ||
          (exp_kind != 2'b00 && {int_kind, int_vector} !== {exp_kind, ref_vec(exp_kind)})) begin
        errors++;
        $display("FAIL irq_req it %0d (irq_n=%b p_i=%b): got req=%b kind=%b vec=%h want kind=%b",
                 it, lvl, msk, int_req, int_kind, int_vector, exp_kind);
      end
      if (exp_kind != 2'b00) begin
        // Committed IRQ must survive the source going away or the mask being set.
        if ($urandom_range(0, 1) == 1) irq_n = 1'b1;
        else p_i = 1'b1;
        step($urandom_range(1, 3));
        checks++;
        if ({int_req, int_kind, int_vector} !== {1'b1, 2'b01, 16'hFFFE}) begin
          errors++;
          $display("FAIL irq_commit it %0d: got req=%b kind=%b vec=%h want 1 01 fffe",
                   it, int_req, int_kind, int_vector);
        end
        int_ack = 1'b1; step(); int_ack = 1'b0;
        int_done = 1'b1; step(); int_done = 1'b0;
      end
    end
    irq_n = 1'b1; p_i = 1'b1;
    step(SYNC_STAGES + 1);
  endtask

  task automatic test_nmi();
    int lat;
    bit seen;
    fetch_boundary = 1'b1;
    nmi_n = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      step();
      if (int_req) lat = i;
    end
    checks++;
    if (lat != SYNC_STAGES + 2) begin
      errors++;
      $display("FAIL nmi_latency: got %0d cycles want %0d", lat, SYNC_STAGES + 2);
    end
    checks++;
    if ({int_kind, int_vector, nmi_pending} !== {2'b10, 16'hFFFA, 1'b1}) begin
      errors++;
      $display("FAIL nmi_req: got kind=%b vec=%h pend=%b want 10 fffa 1",
               int_kind, int_vector, nmi_pending);
    end
    int_ack = 1'b1; step(); int_ack = 1'b0;
    checks++;
    if ({int_req, nmi_pending} !== 2'b00) begin
      errors++;
      $display("FAIL nmi_ack: got req=%b pend=%b want 0 0", int_req, nmi_pending);
    end
    int_done = 1'b1; step(); int_done = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen |= int_req;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL nmi_no_repeat: got a request with nmi_n held low, want none");
    end
    nmi_n = 1'b1; step(SYNC_STAGES + 2);
    nmi_n = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      step();
      if (int_req) lat = i;
    end
    checks++;
    if (lat == 0 || int_kind !== 2'b10) begin
      errors++;
      $display("FAIL nmi_second: got req_seen=%0d kind=%b want request with kind 10",
               lat != 0, int_kind);
    end
    fetch_boundary = 1'b0;
    int_ack = 1'b1; step(); int_ack = 1'b0;
    int_done = 1'b1; step(); int_done = 1'b0;
    nmi_n = 1'b1; step(SYNC_STAGES + 2);
  endtask

  task automatic test_hijack();
    logic [1:0] exp_kind;
    irq_n = 1'b0; p_i = 1'b0;
    step(SYNC_STAGES + 1);
    fetch_boundary = 1'b1; step(); fetch_boundary = 1'b0;
    checks++;
    if ({int_req, int_kind, int_vector} !== {1'b1, 2'b01, 16'hFFFE}) begin
      errors++;
      $display("FAIL hijack_irq: got req=%b kind=%b vec=%h want 1 01 fffe",
               int_req, int_kind, int_vector);
    end
    nmi_n = 1'b0; irq_n = 1'b1;
    for (int k = 1; k <= SYNC_STAGES + 3; k++) begin
      step();
      exp_kind = (k >= SYNC_STAGES + 2) ? 2'b10 : 2'b01;
      checks++;
      if ({int_req, int_kind, int_vector} !== {1'b1, exp_kind, ref_vec(exp_kind)}) begin
        errors++;
        $display("FAIL hijack step %0d: got req=%b kind=%b vec=%h want 1 %b %h",
                 k, int_req, int_kind, int_vector, exp_kind, ref_vec(exp_kind));
      end
    end
    int_ack = 1'b1; step(); int_ack = 1'b0;
    checks++;
    if (nmi_pending !== 1'b0) begin
      errors++;
      $display("FAIL hijack_ack: got pend=%b want 0", nmi_pending);
    end
    int_done = 1'b1; step(); int_done = 1'b0;
    p_i = 1'b1; nmi_n = 1'b1;
    step(SYNC_STAGES + 2);
  endtask

  task automatic test_ack_race();
    int waited;
    nmi_n = 1'b0; fetch_boundary = 1'b1;
    waited = 0;
    while (!int_req && waited < 12) begin
      step();
      waited++;
    end
    fetch_boundary = 1'b0;
    checks++;
    if (int_req !== 1'b1) begin
      errors++;
      $display("FAIL race_setup: got req=%b want 1 within 12 cycles", int_req);
    end
    nmi_n = 1'b1; step(SYNC_STAGES + 2);
    nmi_n = 1'b0; step(SYNC_STAGES);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    checks++;
    if ({int_req, nmi_pending} !== 2'b01) begin
      errors++;
      $display("FAIL race_ack: got req=%b pend=%b want 0 1", int_req, nmi_pending);
    end
    int_done = 1'b1; step(); int_done = 1'b0;
    fetch_boundary = 1'b1; step(); fetch_boundary = 1'b0;
    checks++;
    if ({int_req, int_kind, int_vector} !== {1'b1, 2'b10, 16'hFFFA}) begin
      errors++;
      $display("FAIL race_second: got req=%b kind=%b vec=%h want 1 10 fffa",
               int_req, int_kind, int_vector);
    end
    int_ack = 1'b1; step(); int_ack = 1'b0;
    checks++;
    if (nmi_pending !== 1'b0) begin
      errors++;
      $display("FAIL race_clear: got pend=%b want 0", nmi_pending);
    end
    int_done = 1'b1; step(); int_done = 1'b0;
    nmi_n = 1'b1; step(SYNC_STAGES + 2);
  endtask

  task automatic test_async_reset();
    int waited;
    nmi_n = 1'b0; fetch_boundary = 1'b1;
    waited = 0;
    while (!int_req && waited < 12) begin
      step();
      waited++;
    end
    fetch_boundary = 1'b0;
    int_ack = 1'b1; step(); int_ack = 1'b0;
    nmi_n = 1'b1; step(SYNC_STAGES + 2);
    nmi_n = 1'b0; step(SYNC_STAGES + 1);
    checks++;
    if (nmi_pending !== 1'b1) begin
      errors++;
      $display("FAIL areset_setup: got pend=%b want 1", nmi_pending);
    end
    #3;
    resetn = 1'b0;
    #1;
    checks++;
    if ({int_req, int_kind, int_vector, nmi_pending} !== {1'b0, 2'b11, 16'hFFFC, 1'b0}) begin
      errors++;
      $display("FAIL areset_now: got req=%b kind=%b vec=%h pend=%b want 0 11 fffc 0",
               int_req, int_kind, int_vector, nmi_pending);
    end
    nmi_n = 1'b1;
    step(2);
    resetn = 1'b1;
    for (int i = 1; i <= RST_CYCLES; i++) begin
      step();
      checks++;
      if (int_req !== (i == RST_CYCLES)) begin
        errors++;
        $display("FAIL areset_hold cycle %0d: got req=%b want %b", i, int_req, i == RST_CYCLES);
      end
    end
  endtask

  initial begin
    test_reset();
    test_irq_random();
    test_nmi();
    test_hijack();
    test_ack_race();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
